mda_pixel_serializer: RTL and testbench

Character-to-pixel back end that sits directly downstream of the MC6845 CRTC in the MDA-style display path. Runs on the dot clock and issues the one-dot character-clock enable that advances the CRTC. Each character slot, it samples the CRTC's memory address, row address, display enable, cursor and syncs. It fetches the character and attribute bytes from video RAM and the glyph row from font ROM, applies MDA attribute rules, and serialises the result to monochrome video with syncs delay-matched to the pixels.

---
 rtl/mda_pixel_serializer.sv | 184 ++++++++++++++++++
 tb/tb_mda_pixel_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mda_pixel_serializer.sv
// MDA-style character-to-pixel back end.
// Sits behind the 6845 CRTC on the dot clock: paces the CRTC with a one-dot
// character enable, fetches character/attribute bytes and the glyph row,
// applies monochrome attribute rules and shifts pixels out one per dot with
// syncs and intensity delayed by exactly one character slot.
module mda_pixel_serializer #(
    parameter int         CHAR_WIDTH    = 9,
    parameter logic [4:0] UNDERLINE_ROW = 5'd12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_char_ce,
    input  logic [13:0] i_ma,
    input  logic [4:0]  i_ra,
    input  logic        i_de,
    input  logic        i_cursor,
    input  logic        i_hsync,
    input  logic        i_vsync,
    output logic [11:0] o_vram_addr,
    input  logic [7:0]  i_vram_data,
    output logic [11:0] o_font_addr,
    input  logic [7:0]  i_font_data,
    output logic        o_video,
    output logic        o_intense,
    output logic        o_hsync,
    output logic        o_vsync
);

    localparam logic [3:0] DOT_LAST = 4'(CHAR_WIDTH - 1);

    logic [3:0]  r_dot;
    logic [10:0] r_ma;
    logic [4:0]  r_ra;
    logic        r_de;
    logic        r_cursor;
    logic        r_hs;
    logic        r_vs;
    logic [4:0]  r_frame;
    logic [11:0] r_vram_addr;
    logic [11:0] r_font_addr;
    logic [7:0]  r_chr;
    logic [7:0]  r_atr;
    logic [7:0]  r_glyph;
    logic [8:0]  r_shift;
    logic        r_intense;
    logic        r_hs_out;
    logic        r_vs_out;

    logic        w_dot0;
    logic        w_dot_last;
    logic        w_blank;
    logic        w_reverse;
    logic        w_underline;
    logic        w_blink_off;
    logic        w_cursor_on;
    logic        w_ninth;
    logic [8:0]  w_base;
    logic [8:0]  w_pat;
    logic        w_intense;
    logic        w_unused;

    assign w_dot0      = (r_dot == 4'd0);
    assign w_dot_last  = (r_dot == DOT_LAST);
    assign w_blank     = (r_atr[6:0] == 7'h00) || (r_atr[6:0] == 7'h08);
    assign w_reverse   = (r_atr[6:0] == 7'h70) || (r_atr[6:0] == 7'h78);
    assign w_underline = (r_atr[2:0] == 3'b001) && (r_ra == UNDERLINE_ROW);
    assign w_blink_off = r_atr[7] && r_frame[4];
    assign w_cursor_on = r_cursor && !r_frame[3];
    // Box-drawing characters 0xC0..0xDF stretch their last column into the ninth dot.
    assign w_ninth     = (CHAR_WIDTH == 9) && (r_chr[7:5] == 3'b110) && r_glyph[0];
    assign w_base      = {r_glyph, w_ninth};

    assign o_char_ce   = w_dot_last;
    assign o_vram_addr = r_vram_addr;
    assign o_font_addr = r_font_addr;
    assign o_video     = r_shift[8];
    assign o_intense   = r_intense;
    assign o_hsync     = r_hs_out;
    assign o_vsync     = r_vs_out;

    // Upper MA bits address beyond the 4 KB MDA buffer; low CHR bits only feed the font address.
    assign w_unused    = ^{i_ma[13:11], r_chr[4:0]};

    // Dot counter: 0..CHAR_WIDTH-1, wrapping once per character slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dot <= 4'd0;
        end else if (w_dot_last) begin
            r_dot <= 4'd0;
        end else begin
            r_dot <= r_dot + 4'd1;
        end
    end

    // Slot register and frame counter: CRTC outputs sampled once per slot at dot 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ma     <= '0;
            r_ra     <= '0;
            r_de     <= 1'b0;
            r_cursor <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_frame  <= '0;
        end else if (w_dot0) begin
            r_ma     <= i_ma[10:0];
            r_ra     <= i_ra;
            r_de     <= i_de;
            r_cursor <= i_cursor;
            r_hs     <= i_hsync;
            r_vs     <= i_vsync;
            if (i_vsync && !r_vs) begin
                r_frame <= r_frame + 5'd1;
            end
        end
    end

    // Fetch pipeline. The font address is issued as soon as the character byte
    // arrives so the glyph row is back in time to be latched at dot 4.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vram_addr <= '0;
            r_font_addr <= '0;
            r_chr       <= '0;
            r_atr       <= '0;
            r_glyph     <= '0;
        end else begin
            case (r_dot)
                4'd0: r_vram_addr <= {i_ma[10:0], 1'b0};
                4'd1: r_vram_addr <= {r_ma, 1'b1};
                4'd2: begin
                    r_chr       <= i_vram_data;
                    r_font_addr <= {i_vram_data, r_ra[3:0]};
                end
                4'd3: r_atr   <= i_vram_data;
                4'd4: r_glyph <= i_font_data;
                default: ;
            endcase
        end
    end

    // Attribute rules in priority order: display enable, blank/reverse/normal,
    // blink suppression, then cursor which overrides everything but DE=0.
    always_comb begin
        w_pat     = '0;
        w_intense = 1'b0;
        if (r_de) begin
            if (w_blank) begin
                w_pat = '0;
            end else if (w_reverse) begin
                w_pat = ~w_base;
            end else if (w_underline) begin
                w_pat = '1;
            end else begin
                w_pat = w_base;
            end
            if (w_blink_off) begin
                w_pat = w_reverse ? '1 : '0;
            end
            w_intense = r_atr[3];
            if (w_cursor_on) begin
                w_pat = '1;
            end
        end
    end

    // Output stage: load pattern, intensity and syncs at the slot boundary, shift MSB first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_intense <= 1'b0;
            r_hs_out  <= 1'b0;
            r_vs_out  <= 1'b0;
        end else if (w_dot_last) begin
            r_shift   <= w_pat;
            r_intense <= w_intense;
            r_hs_out  <= r_hs;
            r_vs_out  <= r_vs;
        end else begin
            r_shift   <= {r_shift[7:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_mda_pixel_serializer.sv
// Bench for mda_pixel_serializer: memory models, per-slot reference model,
// directed cases followed by randomized slots.
module tb_mda_pixel_serializer;

    localparam int         CW = 9;
    localparam logic [4:0] UL = 5'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_ce;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        de, cursor, hsync_in, vsync_in;
    logic [11:0] vram_addr, font_addr;
    logic [7:0]  vram_data, font_data;
    logic        video, intense, hsync_out, vsync_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] vram [4096];
    logic [7:0] font [4096];

    int       m_frame;
    bit       m_prev_vs;
    logic [8:0] cur_pat;
    logic       cur_int, cur_hs, cur_vs;
    logic [CW-1:0] obs_v_last, obs_hs_last, obs_int_last;

    always #5 clk = ~clk;

    mda_pixel_serializer #(.CHAR_WIDTH(CW), .UNDERLINE_ROW(UL)) dut (
        .i_clk(clk), .i_rst(rst), .o_char_ce(char_ce),
        .i_ma(ma), .i_ra(ra), .i_de(de), .i_cursor(cursor),
        .i_hsync(hsync_in), .i_vsync(vsync_in),
        .o_vram_addr(vram_addr), .i_vram_data(vram_data),
        .o_font_addr(font_addr), .i_font_data(font_data),
        .o_video(video), .o_intense(intense),
        .o_hsync(hsync_out), .o_vsync(vsync_out)
    );

    // Synchronous memories with one-clock read latency.
    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what one character cell looks like, as {intense, 9-dot pattern}.
    function automatic logic [9:0] model_cell(input logic [7:0] chr, input logic [7:0] atr,
                                              input logic [7:0] glyph, input logic [4:0] row,
                                              input logic en, input logic cur, input int frame);
        logic [8:0] fg, pat;
        bit line_gfx, is_blank, is_rev;
        int a7;
        line_gfx = (chr >= 8'hC0) && (chr <= 8'hDF);
        fg = {glyph, (CW == 9 && line_gfx) ? glyph[0] : 1'b0};
        if (!en) return 10'd0;
        a7 = int'(atr) % 128;
        is_blank = (a7 == 'h00) || (a7 == 'h08);
        is_rev   = (a7 == 'h70) || (a7 == 'h78);
        if (is_blank)                          pat = 9'h000;
        else if (is_rev)                       pat = ~fg;
        else if (atr % 8 == 1 && row == UL)    pat = 9'h1FF;
        else                                   pat = fg;
        if (atr >= 8'd128 && frame >= 16)      pat = is_rev ? 9'h1FF : 9'h000;
        if (cur && (frame % 16) < 8)           pat = 9'h1FF;
        return {atr[3], pat};
    endfunction

    task automatic set_cell(input logic [13:0] a, input logic [7:0] chr, input logic [7:0] atr,
                            input logic [4:0] row, input logic [7:0] glyph);
        vram[{a[10:0], 1'b0}] = chr;
        vram[{a[10:0], 1'b1}] = atr;
        font[{chr, row[3:0]}] = glyph;
    endtask

    task automatic model_reset();
        m_frame   = 0;
        m_prev_vs = 0;
        cur_pat   = '0;
        cur_int   = 0;
        cur_hs    = 0;
        cur_vs    = 0;
    endtask

    // One character slot: called at the falling edge in the dot-0 cycle.
    // Observes the previous slot's output while this slot's character is fetched.
    task automatic run_slot(input logic [13:0] a, input logic [4:0] row, input logic en,
                            input logic cur, input logic hs, input logic vs);
        logic [11:0]   ca;
        logic [7:0]    chr, atr, gl;
        logic [9:0]    r;
        logic [CW-1:0] ov, ohs, ovs, oint, oce;
        ca  = {a[10:0], 1'b0};
        chr = vram[ca];
        atr = vram[ca | 12'd1];
        gl  = font[{chr, row[3:0]}];
        if (vs && !m_prev_vs) m_frame = (m_frame + 1) % 32;
        m_prev_vs = vs;
        r = model_cell(chr, atr, gl, row, en, cur, m_frame);
        ma = a; ra = row; de = en; cursor = cur; hsync_in = hs; vsync_in = vs;
        for (int j = 0; j < CW; j++) begin
            ov[CW-1-j]   = video;
            ohs[CW-1-j]  = hsync_out;
            ovs[CW-1-j]  = vsync_out;
            oint[CW-1-j] = intense;
            oce[CW-1-j]  = char_ce;
            if (j == 1) check("vram_addr_chr", vram_addr, ca);
            if (j == 2) check("vram_addr_atr", vram_addr, ca | 12'd1);
            if (j == 3) check("font_addr", font_addr, {chr, row[3:0]});
            @(posedge clk);
            @(negedge clk);
        end
        check("video", ov, cur_pat[8 -: CW]);
        check("intense", oint, {CW{cur_int}});
        check("hsync_out", ohs, {CW{cur_hs}});
        check("vsync_out", ovs, {CW{cur_vs}});
        check("char_ce", oce, 1);
        obs_v_last   = ov;
        obs_hs_last  = ohs;
        obs_int_last = oint;
        cur_pat = r[8:0];
        cur_int = r[9];
        cur_hs  = hs;
        cur_vs  = vs;
    endtask

    task automatic directed(input string tag, input logic [7:0] chr, input logic [7:0] atr,
                            input logic [4:0] row, input logic [7:0] glyph, input logic en,
                            input logic [8:0] exp_pat);
        set_cell(14'h3805, chr, atr, row, glyph);
        run_slot(14'h3805, row, en, 1'b0, 1'b0, 1'b0);
        run_slot(14'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check(tag, obs_v_last, exp_pat);
    endtask

    logic [7:0] atr_pick [8] = '{8'h00, 8'h08, 8'h70, 8'h78, 8'h01, 8'h81, 8'hF0, 8'h8F};

    initial begin
        logic [13:0] ra_ma;
        logic [4:0]  r_row;
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 8'h00;
            font[i] = 8'h00;
        end
        rst = 1; ma = 0; ra = 0; de = 0; cursor = 0; hsync_in = 0; vsync_in = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_video", video, 0);
        check("reset_outputs", {char_ce, intense, hsync_out, vsync_out, vram_addr, font_addr}, 0);
        rst = 0;

        // Directed attribute cases (frame 0: cursor phase on, blink phase shown).
        directed("tp_normal",   8'h41, 8'h07, 5'd3,  8'h3C, 1'b1, 9'h078);
        check("tp_normal_intense", obs_int_last, 0);
        directed("tp_linegfx",  8'hC4, 8'h07, 5'd3,  8'hFF, 1'b1, 9'h1FF);
        directed("tp_plain_ff", 8'h41, 8'h07, 5'd3,  8'hFF, 1'b1, 9'h1FE);
        directed("tp_reverse",  8'h41, 8'h70, 5'd3,  8'h3C, 1'b1, 9'h187);
        directed("tp_underline",8'h41, 8'h01, 5'd12, 8'h00, 1'b1, 9'h1FF);
        directed("tp_blank",    8'h41, 8'h08, 5'd3,  8'hFF, 1'b1, 9'h000);
        check("tp_blank_intense", obs_int_last, {CW{1'b1}});
        directed("tp_de_off",   8'h41, 8'h07, 5'd3,  8'hFF, 1'b0, 9'h000);

        // Sync alignment: two slots of HSYNC_IN give 18 delayed dots.
        run_slot(14'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_slot(14'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hs_first", obs_hs_last, {CW{1'b1}});
        run_slot(14'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hs_second", obs_hs_last, {CW{1'b1}});
        run_slot(14'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hs_end", obs_hs_last, 0);

        // Reset in the middle of a lit slot.
        set_cell(14'h0123, 8'h20, 8'h01, 5'd12, 8'h00);
        run_slot(14'h0123, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_video", {video, hsync_out}, 2'b11);
        rst = 1;
        #1;
        check("mid_rst_outputs",
              {char_ce, video, intense, hsync_out, vsync_out, vram_addr, font_addr}, 0);
        repeat (2) @(negedge clk);
        ma = 0; ra = 0; de = 0; cursor = 0; hsync_in = 0; vsync_in = 0;
        rst = 0;
        model_reset();
        run_slot(14'h0123, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);

        // Blink and cursor phases across more than a full frame-counter wrap.
        set_cell(14'h0100, 8'h41, 8'h87, 5'd3, 8'h3C);
        set_cell(14'h0101, 8'h42, 8'h07, 5'd3, 8'h3C);
        for (int f = 0; f < 34; f++) begin
            run_slot(14'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            run_slot(14'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            run_slot(14'h0100, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            run_slot(14'h0101, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            check("blink_phase", obs_v_last, (m_frame < 16) ? 9'h078 : 9'h000);
        end

        // Randomized slots against the model.
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 8'($urandom);
            font[i] = 8'($urandom);
        end
        for (int n = 0; n < 400; n++) begin
            ra_ma = 14'($urandom);
            r_row = ($urandom % 4 == 0) ? UL : 5'($urandom);
            if ($urandom % 3 == 0) vram[{ra_ma[10:0], 1'b1}] = atr_pick[$urandom % 8];
            run_slot(ra_ma, r_row, ($urandom % 4) != 0, ($urandom % 8) == 0,
                     ($urandom % 5) == 0, ($urandom % 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
